// File: rtl/board_input_conditioner_if.sv
// Pad-side bundle for the board input conditioner: raw pins in, conditioned events out.
// master: the pad/top side (drives raw pins, consumes conditioned outputs).
// slave : the conditioner itself (samples raw pins, drives conditioned outputs).
interface board_input_conditioner_if #(
  parameter int N_BTN = 4,
  parameter int POS_W = 8
);
  // raw pins (asynchronous to CCLK)
  logic [N_BTN-1:0] btn_raw;
  logic             rot_a;
  logic             rot_b;
  logic             rot_ctr;
  // conditioned outputs (all registered in CCLK domain)
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             rot_ctr_level;
  logic             rot_ctr_press;
  logic             rot_step;
  logic             rot_dir;
  logic [POS_W-1:0] rot_pos;

  modport master (
    output btn_raw, rot_a, rot_b, rot_ctr,
    input  btn_level, btn_press, btn_release, rot_ctr_level, rot_ctr_press,
           rot_step, rot_dir, rot_pos
  );

  modport slave (
    input  btn_raw, rot_a, rot_b, rot_ctr,
    output btn_level, btn_press, btn_release, rot_ctr_level, rot_ctr_press,
           rot_step, rot_dir, rot_pos
  );
endinterface

// File: rtl/board_input_conditioner.sv
// Purpose: synchronise + debounce pushbuttons and rotary encoder, emit press/release pulses and rotary steps/position.
// Latency: stable raw change -> level/pulse after SYNC_STAGES+DEBOUNCE_CYCLES edges; rot_step/rot_pos one edge later.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes, consumers must sample every cycle.
//
// Ports: CCLK (clock), RSTN (async active-low reset), bus (board_input_conditioner_if.slave:
//   raw btn_raw/rot_a/rot_b/rot_ctr in; btn_level/press/release, rot_ctr_level/press,
//   rot_step, rot_dir, rot_pos out).
// Build option: define ROT_SAT_EN to make rot_pos saturate instead of wrapping.
// Parameter minimums: SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 1.
module board_input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int POS_W           = 8
) (
  input logic                       CCLK,
  input logic                       RSTN,
  board_input_conditioner_if.slave  bus
);

  // channel map: buttons first, then rotary A, rotary B, rotary push
  localparam int NCH   = N_BTN + 3;
  localparam int CH_A  = N_BTN;
  localparam int CH_B  = N_BTN + 1;
  localparam int CH_C  = N_BTN + 2;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // counter value at which the next differing cycle completes the debounce
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   synced;
  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [NCH-1:0]   level_q, level_d;

  logic [N_BTN-1:0] btn_press_q, btn_press_d;
  logic [N_BTN-1:0] btn_release_q, btn_release_d;
  logic             ctr_press_q, ctr_press_d;
  logic             a_rise_q, a_rise_d;
  logic             rot_step_q, rot_step_d;
  logic             rot_dir_q, rot_dir_d;
  logic [POS_W-1:0] rot_pos_q, rot_pos_d;

  assign raw    = {bus.rot_ctr, bus.rot_b, bus.rot_a, bus.btn_raw};
  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Debounce: count consecutive cycles where synced disagrees with the accepted level;
  // any agreeing cycle restarts the count, so glitches never reach the level.
  always_comb begin
    level_d = level_q;
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (synced[ch] == level_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == DB_LAST) begin
        level_d[ch] = synced[ch];
        cnt_d[ch]   = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Edge strobes are taken from the level transition so they coincide with the new level.
  always_comb begin
    btn_press_d   = level_d[N_BTN-1:0] & ~level_q[N_BTN-1:0];
    btn_release_d = ~level_d[N_BTN-1:0] & level_q[N_BTN-1:0];
    ctr_press_d   = level_d[CH_C] & ~level_q[CH_C];
    a_rise_d      = level_d[CH_A] & ~level_q[CH_A];

    // direction uses the B level as it stands after this edge's update
    rot_dir_d = rot_dir_q;
    if (a_rise_d) rot_dir_d = ~level_d[CH_B];

    // step and count land one edge after the A rise, using the freshly latched direction
    rot_step_d = a_rise_q;
    rot_pos_d  = rot_pos_q;
    if (a_rise_q) begin
`ifdef ROT_SAT_EN
      if (rot_dir_q) begin
        if (rot_pos_q != POS_MAX) rot_pos_d = rot_pos_q + POS_W'(1);
      end else begin
        if (rot_pos_q != POS_MIN) rot_pos_d = rot_pos_q - POS_W'(1);
      end
`else
      if (rot_dir_q) rot_pos_d = rot_pos_q + POS_W'(1);
      else           rot_pos_d = rot_pos_q - POS_W'(1);
`endif
    end
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int ch = 0; ch < NCH; ch++) cnt_q[ch] <= '0;
      level_q       <= '0;
      btn_press_q   <= '0;
      btn_release_q <= '0;
      ctr_press_q   <= 1'b0;
      a_rise_q      <= 1'b0;
      rot_step_q    <= 1'b0;
      rot_dir_q     <= 1'b0;
      rot_pos_q     <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) cnt_q[ch] <= cnt_d[ch];
      level_q       <= level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      ctr_press_q   <= ctr_press_d;
      a_rise_q      <= a_rise_d;
      rot_step_q    <= rot_step_d;
      rot_dir_q     <= rot_dir_d;
      rot_pos_q     <= rot_pos_d;
    end
  end

  assign bus.btn_level     = level_q[N_BTN-1:0];
  assign bus.btn_press     = btn_press_q;
  assign bus.btn_release   = btn_release_q;
  assign bus.rot_ctr_level = level_q[CH_C];
  assign bus.rot_ctr_press = ctr_press_q;
  assign bus.rot_step      = rot_step_q;
  assign bus.rot_dir       = rot_dir_q;
  assign bus.rot_pos       = rot_pos_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: directed scenarios plus randomized input bursts.
// A reference model predicts every cycle's outputs into a queue; a monitor pops and compares.
module tb_board_input_conditioner;

  localparam int NB  = 4;
  localparam int S   = 2;
  localparam int D   = 4;
  localparam int PW  = 8;
  localparam int NCH = NB + 3;

  logic CCLK;
  logic RSTN;

  board_input_conditioner_if #(.N_BTN(NB), .POS_W(PW)) bif ();

  board_input_conditioner #(
    .N_BTN(NB), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .POS_W(PW)
  ) dut (
    .CCLK(CCLK),
    .RSTN(RSTN),
    .bus (bif)
  );

  initial CCLK = 1'b0;
  always #10 CCLK = ~CCLK;

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic          clvl;
    logic          cprs;
    logic          step;
    logic          dir;
    logic [PW-1:0] pos;
  } snap_t;

  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  // ---------------- reference model ----------------
  // A channel's accepted level flips once its synchronised input has disagreed with
  // it for D consecutive edges; the synchronised input is the raw pin S edges ago.
  bit [NCH-1:0] samp[$];
  bit [NCH-1:0] m_lvl;
  bit           m_pend, m_dir;
  int           m_pos;
  snap_t        m_out;

  function automatic void model_clear();
    m_lvl  = '0;
    m_pend = 1'b0;
    m_dir  = 1'b0;
    m_pos  = 0;
    m_out  = '0;
    samp.delete();
    for (int i = 0; i < S + D + 2; i++) samp.push_back('0);
  endfunction

  initial model_clear();

  // reset erases everything held inside the conditioner, including in-flight samples
  always @(negedge RSTN) begin
    model_clear();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
  end

  always @(posedge CCLK) begin
    bit [NCH-1:0] nl, rise, fall;
    int sz;
    bit fire;
    if (!RSTN) begin
      samp.push_back('0);
      m_out = '0;
    end else begin
      samp.push_back({bif.rot_ctr, bif.rot_b, bif.rot_a, bif.btn_raw});
      sz = samp.size();
      nl = m_lvl;
      for (int ch = 0; ch < NCH; ch++) begin
        fire = 1'b1;
        for (int j = 0; j < D; j++)
          if (samp[sz-1-S-j][ch] == m_lvl[ch]) fire = 1'b0;
        if (fire) nl[ch] = ~m_lvl[ch];
      end
      rise = nl & ~m_lvl;
      fall = ~nl & m_lvl;
      m_out.step = m_pend;
      if (m_pend) begin
        m_pos = m_dir ? m_pos + 1 : m_pos - 1;
`ifdef ROT_SAT_EN
        if (m_pos > 127)  m_pos = 127;
        if (m_pos < -128) m_pos = -128;
`endif
      end
      if (rise[NB]) m_dir = ~nl[NB+1];
      m_pend = rise[NB];
      m_lvl  = nl;
      m_out.lvl  = nl[NB-1:0];
      m_out.prs  = rise[NB-1:0];
      m_out.rel  = fall[NB-1:0];
      m_out.clvl = nl[NB+2];
      m_out.cprs = rise[NB+2];
      m_out.dir  = m_dir;
      m_out.pos  = PW'(m_pos);
    end
    exp_q.push_back(m_out);
    while (samp.size() > S + D + 4) void'(samp.pop_front());
  end

  // ---------------- monitor ----------------
  initial begin
    snap_t e, a;
    forever begin
      @(negedge CCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bif.btn_level, bif.btn_press, bif.btn_release, bif.rot_ctr_level,
             bif.rot_ctr_press, bif.rot_step, bif.rot_dir, bif.rot_pos};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got lvl=%b prs=%b rel=%b clvl=%b cprs=%b step=%b dir=%b pos=%h | want lvl=%b prs=%b rel=%b clvl=%b cprs=%b step=%b dir=%b pos=%h",
                   $time, a.lvl, a.prs, a.rel, a.clvl, a.cprs, a.step, a.dir, a.pos,
                   e.lvl, e.prs, e.rel, e.clvl, e.cprs, e.step, e.dir, e.pos);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // inputs change 2 ns after a rising edge and are sampled at the next one
  task automatic cyc(input int n);
    repeat (n) @(posedge CCLK);
    #2;
  endtask

  task automatic set_ch(input int ch, input bit v);
    case (ch)
      NB:      bif.rot_a = v;
      NB + 1:  bif.rot_b = v;
      NB + 2:  bif.rot_ctr = v;
      default: bif.btn_raw[ch] = v;
    endcase
  endtask

  task automatic a_cycle();
    bif.rot_a = 1'b1;
    cyc(8);
    bif.rot_a = 1'b0;
    cyc(8);
  endtask

  // reset asserted and released mid-cycle, away from any clock edge
  task automatic mid_reset(input int hold);
    #3 RSTN = 1'b0;
    repeat (hold) @(posedge CCLK);
    #5 RSTN = 1'b1;
    cyc(1);
  endtask

  initial begin
    RSTN        = 1'b0;
    bif.btn_raw = '0;
    bif.rot_a   = 1'b0;
    bif.rot_b   = 1'b0;
    bif.rot_ctr = 1'b0;
    repeat (3) @(posedge CCLK);
    #5 RSTN = 1'b1;
    cyc(2);

    // press, glitch, release
    bif.btn_raw[1] = 1'b1; cyc(10);
    bif.btn_raw[2] = 1'b1; cyc(3);
    bif.btn_raw[2] = 1'b0; cyc(8);
    bif.btn_raw[1] = 1'b0; cyc(10);

    // rotary clockwise then counter-clockwise
    bif.rot_b = 1'b0;
    repeat (3) a_cycle();
    bif.rot_b = 1'b1; cyc(8);
    repeat (5) a_cycle();

    // run through the positive limit: 0xFE + 130 steps
    bif.rot_b = 1'b0; cyc(8);
    repeat (130) a_cycle();

    // concurrent button 3 and rotary push
    bif.btn_raw[3] = 1'b1;
    bif.rot_ctr    = 1'b1;
    cyc(10);
    bif.btn_raw[3] = 1'b0;
    bif.rot_ctr    = 1'b0;
    cyc(10);

    // async reset in the middle of a debounce, with another level already high
    bif.btn_raw[1] = 1'b1; cyc(10);
    bif.btn_raw[0] = 1'b1; cyc(3);
    mid_reset(2);
    cyc(12);
    bif.btn_raw = '0; cyc(10);

    // randomized bursts on random channels, occasional resets
    for (int k = 0; k < 400; k++) begin
      set_ch($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) mid_reset($urandom_range(0, 2));
      else cyc($urandom_range(1, 10));
    end
    cyc(10);

    // every predicted cycle must have been consumed by the monitor
    @(posedge CCLK); #1;
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL drain: pending=%0d want<=1", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
